// File: rtl/cnn_conv_stream.sv
// cnn_conv_stream
//   Streaming KxK valid-window convolution with NUM_CH parallel output
//   channels. Raster pixels are shifted through K-1 line buffers into a KxK
//   window register. Each completed window is multiply-accumulated against a
//   per-channel kernel (stage 1). The result is shifted, ReLU-clamped and
//   saturated (stage 2) and presented on the master stream.
//   The whole pipeline freezes while the output is stalled, so no output FIFO
//   is needed.
//
// Ports
//   clk_i, rst_i        single clock, synchronous active-high reset
//   s_axis_*            input pixel stream; tlast marks the last frame pixel
//   m_axis_*            output stream; channel c at tdata[c*DATA_RES +: DATA_RES]
//   w_we_i/w_addr_i/
//   w_data_i            shadow weight write; addr = c*K*K + r*K + k
//                       (r=0 oldest line, k=0 oldest column)
//   frame_err_o         sticky tlast/position mismatch flag
module cnn_conv_stream #(
  parameter int DATA_RES     = 8,
  parameter int WEIGHT_RES   = 8,
  parameter int LINE_WIDTH   = 28,
  parameter int FRAME_HEIGHT = 28,
  parameter int KERNEL_WIDTH = 3,
  parameter int NUM_CH       = 4,
  parameter int OUT_SHIFT    = 4
) (
  input  logic                                                     clk_i,
  input  logic                                                     rst_i,
  input  logic [DATA_RES-1:0]                                      s_axis_tdata,
  input  logic                                                     s_axis_tvalid,
  output logic                                                     s_axis_tready,
  input  logic                                                     s_axis_tlast,
  output logic [NUM_CH*DATA_RES-1:0]                               m_axis_tdata,
  output logic                                                     m_axis_tvalid,
  input  logic                                                     m_axis_tready,
  output logic                                                     m_axis_tlast,
  input  logic                                                     w_we_i,
  input  logic [$clog2(NUM_CH*KERNEL_WIDTH*KERNEL_WIDTH)-1:0]      w_addr_i,
  input  logic [WEIGHT_RES-1:0]                                    w_data_i,
  output logic                                                     frame_err_o
);

  localparam int KS    = KERNEL_WIDTH * KERNEL_WIDTH;
  localparam int NW    = NUM_CH * KS;
  localparam int ACC_W = DATA_RES + WEIGHT_RES + $clog2(KS) + 1;
  localparam int COL_W = $clog2(LINE_WIDTH);
  localparam int ROW_W = $clog2(FRAME_HEIGHT);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_WIN  = COL_W'(KERNEL_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(KERNEL_WIDTH - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << DATA_RES) - 1);

  logic                      en;
  logic                      accept;
  logic [COL_W-1:0]          col;
  logic [ROW_W-1:0]          row;
  logic                      last_pix;
  logic                      win_done;

  logic [DATA_RES-1:0]       line_buf [KERNEL_WIDTH-1][LINE_WIDTH];
  logic [DATA_RES-1:0]       new_col  [KERNEL_WIDTH];
  logic [DATA_RES-1:0]       win      [KERNEL_WIDTH][KERNEL_WIDTH];
  logic                      win_vld;
  logic                      win_last;

  logic signed [WEIGHT_RES-1:0] w_shadow [NW];
  logic signed [WEIGHT_RES-1:0] w_active [NW];

  logic signed [ACC_W-1:0]   acc_next [NUM_CH];
  logic signed [ACC_W-1:0]   acc      [NUM_CH];
  logic signed [ACC_W-1:0]   acc_sh   [NUM_CH];
  logic                      s1_vld;
  logic                      s1_last;
  logic [DATA_RES-1:0]       y_sat    [NUM_CH];
  logic                      frame_err;

  // Everything downstream of the input freezes while the output is stalled.
  assign en            = !(m_axis_tvalid && !m_axis_tready);
  assign s_axis_tready = en && !rst_i;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign last_pix      = (row == ROW_LAST) && (col == COL_LAST);
  assign win_done      = (row >= ROW_WIN) && (col >= COL_WIN);
  assign frame_err_o   = frame_err;

  // Column entering the window: older lines from the line buffers, newest
  // line is the incoming pixel.
  always_comb begin
    for (int r = 0; r < KERNEL_WIDTH - 1; r++) begin
      new_col[r] = line_buf[r][col];
    end
    new_col[KERNEL_WIDTH-1] = s_axis_tdata;
  end

  // Line storage carries no reset; row/col gating decides validity.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int r = 0; r < KERNEL_WIDTH - 1; r++) begin
        line_buf[r][col] <= new_col[r+1];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      acc_next[c] = '0;
      for (int r = 0; r < KERNEL_WIDTH; r++) begin
        for (int k = 0; k < KERNEL_WIDTH; k++) begin
          acc_next[c] = acc_next[c] +
            ($signed({{(ACC_W-DATA_RES){1'b0}}, win[r][k]}) *
             $signed({{(ACC_W-WEIGHT_RES){w_active[c*KS + r*KERNEL_WIDTH + k][WEIGHT_RES-1]}},
                      w_active[c*KS + r*KERNEL_WIDTH + k]}));
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      acc_sh[c] = acc[c] >>> OUT_SHIFT;
      if (acc_sh[c][ACC_W-1]) begin
        y_sat[c] = '0;
      end else if (acc_sh[c] > Y_MAX) begin
        y_sat[c] = '1;
      end else begin
        y_sat[c] = acc_sh[c][DATA_RES-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col           <= '0;
      row           <= '0;
      frame_err     <= 1'b0;
      win_vld       <= 1'b0;
      win_last      <= 1'b0;
      s1_vld        <= 1'b0;
      s1_last       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      for (int i = 0; i < NW; i++) begin
        w_shadow[i] <= '0;
        w_active[i] <= '0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c] <= '0;
      end
      for (int r = 0; r < KERNEL_WIDTH; r++) begin
        for (int k = 0; k < KERNEL_WIDTH; k++) begin
          win[r][k] <= '0;
        end
      end
    end else begin
      if (w_we_i && (int'(w_addr_i) < NW)) begin
        w_shadow[w_addr_i] <= $signed(w_data_i);
      end

      if (accept) begin
        // Bank swap only at the first pixel of a frame, so a frame in flight
        // never mixes kernels.
        if ((row == '0) && (col == '0)) begin
          w_active <= w_shadow;
        end
        for (int r = 0; r < KERNEL_WIDTH; r++) begin
          for (int k = 0; k < KERNEL_WIDTH - 1; k++) begin
            win[r][k] <= win[r][k+1];
          end
          win[r][KERNEL_WIDTH-1] <= new_col[r];
        end
        if (last_pix) begin
          col <= '0;
          row <= '0;
          if (!s_axis_tlast) frame_err <= 1'b1;
        end else if (s_axis_tlast) begin
          // Early tlast: resynchronise so the next pixel starts a frame.
          col       <= '0;
          row       <= '0;
          frame_err <= 1'b1;
        end else if (col == COL_LAST) begin
          col <= '0;
          row <= row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end

      if (en) begin
        win_vld       <= accept && win_done;
        win_last      <= accept && last_pix;
        s1_vld        <= win_vld;
        s1_last       <= win_last;
        m_axis_tvalid <= s1_vld;
        m_axis_tlast  <= s1_vld && s1_last;
        if (win_vld) begin
          acc <= acc_next;
        end
        if (s1_vld) begin
          for (int c = 0; c < NUM_CH; c++) begin
            m_axis_tdata[c*DATA_RES +: DATA_RES] <= y_sat[c];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cnn_conv_stream.sv
// tb_cnn_conv_stream
//   Directed bench for cnn_conv_stream with default parameters (28x28 frame,
//   3x3 kernel, 4 channels, shift 4). Each test task drives a scenario and
//   checks outputs collected by a negedge monitor.
module tb_cnn_conv_stream;

  localparam int LW   = 28;
  localparam int NPIX = 784;
  localparam int NOUT = 676;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic        w_we = 1'b0;
  logic [5:0]  w_addr = '0;
  logic [7:0]  w_data = '0;
  logic        frame_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]  pix_mem [NPIX];
  int          acc_cyc [NPIX];
  int          wk [4][4][9];
  logic [31:0] out_data [$];
  logic        out_last [$];
  int          out_cyc  [$];
  int          acc_cnt = 0;
  int          stall_viol = 0;
  logic        bp_mode = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] hold_data = '0;
  logic        hold_last = 1'b0;

  cnn_conv_stream dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .w_we_i        (w_we),
    .w_addr_i      (w_addr),
    .w_data_i      (w_data),
    .frame_err_o   (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_tready = bp_mode ? (int'($urandom_range(99)) >= 30) : 1'b1;
    end
  end

  // Monitor: records handshakes and watches stall stability.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (s_tvalid && s_tready) acc_cnt++;
      if (stall_prev) begin
        if (!m_tvalid || m_tdata !== hold_data || m_tlast !== hold_last) stall_viol++;
      end
      if (m_tvalid && m_tready) begin
        out_data.push_back(m_tdata);
        out_last.push_back(m_tlast);
        out_cyc.push_back(cyc);
      end
      if (m_tvalid && !m_tready) begin
        if (s_tready) stall_viol++;
        stall_prev = 1'b1;
        hold_data  = m_tdata;
        hold_last  = m_tlast;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_outputs();
    out_data.delete();
    out_last.delete();
    out_cyc.delete();
  endtask

  task automatic load_weights(input int sel);
    for (int a = 0; a < 36; a++) begin
      w_we   = 1'b1;
      w_addr = 6'(a);
      w_data = 8'(wk[sel][a/9][a%9]);
      tick();
    end
    w_we = 1'b0;
  endtask

  task automatic send_pixels(input int first, input int last, input int gap_pct, input int tlast_idx);
    for (int i = first; i <= last; i++) begin
      int t;
      while (int'($urandom_range(99)) < gap_pct) begin
        s_tvalid = 1'b0;
        tick();
      end
      s_tvalid = 1'b1;
      s_tdata  = pix_mem[i];
      s_tlast  = (i == tlast_idx);
      t = 0;
      @(negedge clk);
      while (!s_tready && t < 500) begin
        t++;
        @(negedge clk);
      end
      if (!s_tready) begin
        total++;
        bad++;
        $display("FAIL send_timeout pixel=%0d tready=0 want 1", i);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        return;
      end
      tick();
      acc_cyc[i] = cyc;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    for (int t = 0; t < 20000 && out_data.size() < n; t++) tick();
    repeat (6) tick();
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < NPIX; i++) pix_mem[i] = 8'(i);
  endtask

  function automatic logic [31:0] model_out(input int n, input int sel);
    int r, c, s, y;
    logic [31:0] v;
    r = 2 + n / 26;
    c = 2 + n % 26;
    v = '0;
    for (int ch = 0; ch < 4; ch++) begin
      s = 0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          s += int'(pix_mem[(r-2+i)*LW + (c-2+j)]) * wk[sel][ch][i*3+j];
      y = s >>> 4;
      if (y < 0) y = 0;
      if (y > 255) y = 255;
      v[ch*8 +: 8] = 8'(y);
    end
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", m_tvalid); end
    total++; if (m_tdata !== 32'h0) begin bad++; $display("FAIL reset_tdata got=%h want=0", m_tdata); end
    total++; if (m_tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b want=0", m_tlast); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", frame_err); end
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL reset_tready got=%b want=0", s_tready); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL post_reset_tready got=%b want=1", s_tready); end
    tick();
  endtask

  task automatic test_identity();
    load_weights(0);
    fill_ramp();
    clear_outputs();
    send_pixels(0, NPIX-1, 0, NPIX-1);
    wait_outputs(NOUT);
    total++;
    if (out_data.size() != NOUT) begin bad++; $display("FAIL ident_count got=%0d want=%0d", out_data.size(), NOUT); end
    for (int n = 0; n < out_data.size() && n < NOUT; n++) begin
      int r, c;
      logic [31:0] exp_v;
      r = 2 + n / 26;
      c = 2 + n % 26;
      exp_v = {24'h0, 8'((r-1)*LW + (c-1))};
      total++;
      if (out_data[n] !== exp_v) begin bad++; $display("FAIL ident_data n=%0d got=%h want=%h", n, out_data[n], exp_v); end
      total++;
      if (out_last[n] !== (n == NOUT-1)) begin bad++; $display("FAIL ident_last n=%0d got=%b want=%b", n, out_last[n], (n == NOUT-1)); end
    end
    if (out_data.size() > 0) begin
      total++;
      if (out_cyc[0] - acc_cyc[58] != 2) begin bad++; $display("FAIL ident_latency got=%0d want=2", out_cyc[0] - acc_cyc[58]); end
    end
  endtask

  task automatic test_arith();
    int k0 [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    for (int i = 0; i < 9; i++) begin
      wk[1][0][i] = k0[i];
      wk[1][1][i] = -1;
      wk[1][2][i] = 127;
      wk[1][3][i] = 0;
    end
    load_weights(1);
    for (int pass = 0; pass < 2; pass++) begin
      logic [7:0]  pv;
      logic [31:0] exp_v;
      pv    = (pass == 0) ? 8'd160 : 8'd255;
      exp_v = (pass == 0) ? 32'h00FF00A0 : 32'h00FF00FF;
      for (int i = 0; i < NPIX; i++) pix_mem[i] = pv;
      clear_outputs();
      send_pixels(0, NPIX-1, 0, NPIX-1);
      wait_outputs(NOUT);
      total++;
      if (out_data.size() != NOUT) begin bad++; $display("FAIL arith_count pass=%0d got=%0d want=%0d", pass, out_data.size(), NOUT); end
      for (int n = 0; n < out_data.size() && n < NOUT; n++) begin
        total++;
        if (out_data[n] !== exp_v) begin bad++; $display("FAIL arith_data pass=%0d n=%0d got=%h want=%h", pass, n, out_data[n], exp_v); end
      end
    end
  endtask

  task automatic test_backpressure();
    for (int ch = 0; ch < 4; ch++)
      for (int i = 0; i < 9; i++) wk[2][ch][i] = 0;
    wk[2][0][4] = 16;
    wk[2][1][0] = 16;
    for (int i = 0; i < 9; i++) wk[2][2][i] = 1;
    wk[2][3][4] = -16;
    load_weights(2);
    for (int i = 0; i < NPIX; i++) pix_mem[i] = 8'($urandom_range(255));
    clear_outputs();
    stall_viol = 0;
    bp_mode = 1'b1;
    send_pixels(0, NPIX-1, 20, NPIX-1);
    wait_outputs(NOUT);
    bp_mode = 1'b0;
    tick();
    total++;
    if (out_data.size() != NOUT) begin bad++; $display("FAIL bp_count got=%0d want=%0d", out_data.size(), NOUT); end
    for (int n = 0; n < out_data.size() && n < NOUT; n++) begin
      logic [31:0] exp_v;
      exp_v = model_out(n, 2);
      total++;
      if (out_data[n] !== exp_v) begin bad++; $display("FAIL bp_data n=%0d got=%h want=%h", n, out_data[n], exp_v); end
      total++;
      if (out_last[n] !== (n == NOUT-1)) begin bad++; $display("FAIL bp_last n=%0d got=%b want=%b", n, out_last[n], (n == NOUT-1)); end
    end
    total++;
    if (stall_viol != 0) begin bad++; $display("FAIL bp_stall_stability violations=%0d want=0", stall_viol); end
  endtask

  task automatic test_shadow_swap();
    for (int ch = 0; ch < 4; ch++)
      for (int i = 0; i < 9; i++) wk[3][ch][i] = wk[0][ch][i];
    wk[3][0][4] = 0;
    wk[3][0][0] = 16;
    load_weights(0);
    fill_ramp();
    clear_outputs();
    acc_cnt = 0;
    fork
      send_pixels(0, NPIX-1, 0, NPIX-1);
      begin
        for (int t = 0; t < 5000 && acc_cnt < 300; t++) tick();
        w_we = 1'b1; w_addr = 6'd4; w_data = 8'd0;
        tick();
        w_addr = 6'd0; w_data = 8'd16;
        tick();
        w_we = 1'b0;
      end
    join
    send_pixels(0, NPIX-1, 0, NPIX-1);
    wait_outputs(2*NOUT);
    total++;
    if (out_data.size() != 2*NOUT) begin bad++; $display("FAIL swap_count got=%0d want=%0d", out_data.size(), 2*NOUT); end
    for (int n = 0; n < out_data.size() && n < 2*NOUT; n++) begin
      logic [31:0] exp_v;
      exp_v = (n < NOUT) ? model_out(n, 0) : model_out(n - NOUT, 3);
      total++;
      if (out_data[n] !== exp_v) begin bad++; $display("FAIL swap_data n=%0d got=%h want=%h", n, out_data[n], exp_v); end
    end
  endtask

  task automatic test_frame_err();
    load_weights(0);
    fill_ramp();
    clear_outputs();
    total++;
    if (frame_err !== 1'b0) begin bad++; $display("FAIL ferr_initial got=%b want=0", frame_err); end
    send_pixels(0, 100, 0, 100);
    @(negedge clk);
    total++;
    if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_rise got=%b want=1", frame_err); end
    tick();
    wait_outputs(41);
    total++;
    if (out_data.size() != 41) begin bad++; $display("FAIL ferr_partial_count got=%0d want=41", out_data.size()); end
    for (int n = 0; n < out_data.size() && n < 41; n++) begin
      total++;
      if (out_data[n] !== model_out(n, 0)) begin bad++; $display("FAIL ferr_partial_data n=%0d got=%h want=%h", n, out_data[n], model_out(n, 0)); end
    end
    clear_outputs();
    send_pixels(0, 57, 0, -1);
    repeat (6) tick();
    total++;
    if (out_data.size() != 0) begin bad++; $display("FAIL ferr_early_output got=%0d want=0", out_data.size()); end
    send_pixels(58, NPIX-1, 0, NPIX-1);
    wait_outputs(NOUT);
    total++;
    if (out_data.size() != NOUT) begin bad++; $display("FAIL ferr_resync_count got=%0d want=%0d", out_data.size(), NOUT); end
    for (int n = 0; n < out_data.size() && n < NOUT; n++) begin
      total++;
      if (out_data[n] !== model_out(n, 0)) begin bad++; $display("FAIL ferr_resync_data n=%0d got=%h want=%h", n, out_data[n], model_out(n, 0)); end
    end
    if (out_data.size() > 0) begin
      total++;
      if (out_cyc[0] - acc_cyc[58] != 2) begin bad++; $display("FAIL ferr_latency got=%0d want=2", out_cyc[0] - acc_cyc[58]); end
    end
    total++;
    if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_sticky got=%b want=1", frame_err); end
  endtask

  task automatic test_reset_mid();
    load_weights(0);
    fill_ramp();
    clear_outputs();
    send_pixels(0, 399, 0, -1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL mid_reset_tvalid got=%b want=0", m_tvalid); end
    total++; if (m_tdata !== 32'h0) begin bad++; $display("FAIL mid_reset_tdata got=%h want=0", m_tdata); end
    total++; if (m_tlast !== 1'b0) begin bad++; $display("FAIL mid_reset_tlast got=%b want=0", m_tlast); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL mid_reset_err got=%b want=0", frame_err); end
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL mid_reset_tready got=%b want=0", s_tready); end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    clear_outputs();
    send_pixels(0, NPIX-1, 0, NPIX-1);
    wait_outputs(NOUT);
    total++;
    if (out_data.size() != NOUT) begin bad++; $display("FAIL zero_w_count got=%0d want=%0d", out_data.size(), NOUT); end
    for (int n = 0; n < out_data.size() && n < NOUT; n++) begin
      total++;
      if (out_data[n] !== 32'h0) begin bad++; $display("FAIL zero_w_data n=%0d got=%h want=0", n, out_data[n]); end
    end
    load_weights(0);
    clear_outputs();
    send_pixels(0, NPIX-1, 0, NPIX-1);
    wait_outputs(NOUT);
    total++;
    if (out_data.size() != NOUT) begin bad++; $display("FAIL reload_count got=%0d want=%0d", out_data.size(), NOUT); end
    for (int n = 0; n < out_data.size() && n < NOUT; n++) begin
      total++;
      if (out_data[n] !== model_out(n, 0)) begin bad++; $display("FAIL reload_data n=%0d got=%h want=%h", n, out_data[n], model_out(n, 0)); end
      total++;
      if (out_last[n] !== (n == NOUT-1)) begin bad++; $display("FAIL reload_last n=%0d got=%b want=%b", n, out_last[n], (n == NOUT-1)); end
    end
  endtask

  initial begin
    for (int s = 0; s < 4; s++)
      for (int ch = 0; ch < 4; ch++)
        for (int i = 0; i < 9; i++) wk[s][ch][i] = 0;
    wk[0][0][4] = 16;
    test_reset();
    test_identity();
    test_arith();
    test_backpressure();
    test_shadow_swap();
    test_frame_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnn_conv_stream.md
# cnn_conv_stream

Streaming K×K valid-window convolution engine with NUM_CH parallel output channels, runtime-loadable double-buffered weights, full AXI-stream backpressure and frame-aware TLAST. It replaces the fixed-kernel, single-channel convolution top: raster pixels enter on the slave stream, pass through internal line buffers and a window register, and leave as packed, requantised, ReLU-saturated feature pixels on the master stream without an external output FIFO.

## Interface
- DATA_RES, 8: pixel and output-channel width (pixels unsigned).
- WEIGHT_RES, 8: weight width, two's complement.
- LINE_WIDTH, 28: pixels per input line, minimum KERNEL_WIDTH.
- FRAME_HEIGHT, 28: lines per input frame, minimum KERNEL_WIDTH.
- KERNEL_WIDTH, 3: window edge K, minimum 2; KERNEL_SIZE = K*K is derived, not a parameter.
- NUM_CH, 4: output channels, each with its own kernel.
- OUT_SHIFT, 4: arithmetic right shift applied before saturation.
- clk_i in 1: single clock.
- rst_i in 1: synchronous, active-high reset.
- s_axis_tdata in DATA_RES: input pixel.
- s_axis_tvalid in 1 / s_axis_tready out 1 / s_axis_tlast in 1: input stream; tlast marks last pixel of a frame.
- m_axis_tdata out NUM_CH*DATA_RES: channel c at bits [c*DATA_RES +: DATA_RES].
- m_axis_tvalid out 1 / m_axis_tready in 1 / m_axis_tlast out 1: output stream.
- w_we_i in 1 / w_addr_i in clog2(NUM_CH*KERNEL_SIZE) / w_data_i in WEIGHT_RES: shadow-weight write port; addr = c*KERNEL_SIZE + r*K + k, r=0 oldest line, k=0 oldest column.
- frame_err_o out 1: sticky; set on a tlast/position mismatch.

## Operation
- Accept = s_axis_tvalid && s_axis_tready. Pipeline enable en = !(m_axis_tvalid && !m_axis_tready); s_axis_tready = en && !rst_i.
- Position counters col (0..LINE_WIDTH-1), row (0..FRAME_HEIGHT-1) advance on accept only; col wraps to 0 and increments row; at (FRAME_HEIGHT-1, LINE_WIDTH-1) both wrap to 0.
- K-1 line buffers of LINE_WIDTH entries plus a K×K window register shift on accept only.
- A window is complete when the accepted pixel has row >= K-1 and col >= K-1; giving (LINE_WIDTH-K+1)*(FRAME_HEIGHT-K+1) outputs per frame. Windows never straddle lines.
- Stage 1 (sum): acc_c = sum of pixel (zero-extended) × signed weight, width DATA_RES+WEIGHT_RES+clog2(KERNEL_SIZE)+1, no overflow.
- Stage 2 (output): y_c = acc_c >>> OUT_SHIFT; clamp to [0, 2^DATA_RES-1] (ReLU + saturate).
- m_axis_tlast = 1 on the output from the window ending at the last frame pixel.
- Weights: writes always go to the shadow bank (last write wins). Active bank <= shadow on the accept edge of the pixel at (0,0). The frame in flight never sees a mid-frame change.
- Input tlast on a pixel that is not the last frame pixel: set frame_err_o, process the pixel normally, then force counters to (0,0). Missing tlast on the last pixel: set frame_err_o, normal wrap.

## Timing
- Reset (rst_i high at an edge): m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, frame_err_o=0, s_axis_tready=0 while rst_i is high. Counters go to (0,0), line buffers and window are invalid, both weight banks are zeroed. Reset mid-frame discards all in-flight data.
- Latency: a window completed by an accept at edge E presents m_axis_tvalid=1 after edge E+2 when not stalled.
- Stall: while m_axis_tvalid && !m_axis_tready, both stages, counters and window hold. m_axis_tdata/tlast stay stable and s_axis_tready=0.
- Simultaneous output handshake and input accept in one cycle: permitted; throughput is 1 pixel/clock.
- A bubble (no accept) propagates as stage-valid=0. It creates no spurious output.

## Test plan
- Identity: ch0 centre weight = 16, all others 0; 28×28 ramp pixel = (row*28+col)&0xFF; m_tready=1. Expect 676 outputs, ch0 = centre pixel, ch1..3 = 0, tlast only on output 676, first output 2 cycles after accepting pixel (2,2).
- Arithmetic: constant input 160. Ch0 kernel 1,2,1/2,4,2/1,2,1 gives 160. Ch1 all −1 gives 0 (ReLU). Ch2 all 127 with input 255 gives 255 (saturate). Ch3 all 0 gives 0.
- Backpressure: random m_tready with 30% low, random s_tvalid gaps. Output sequence must match the model exactly, tdata/tlast stable while stalled, and no accept while stalled.
- Shadow swap: write a new ch0 kernel at input pixel 300 of frame 1. All of frame 1 must use the old kernel; frame 2 must use the new one from its first output.
- Framing error: assert s_tlast on pixel 100. frame_err_o must rise and stay high; pixel 101 is treated as (0,0), giving the first output after 58 more accepts.
- Reset mid-frame at pixel 400: outputs go to 0 the cycle after, weights read back as 0 in the outputs. After a weight reload, a full frame gives the correct 676 outputs.
